// File: rtl/ball_position_buffer.sv
// ball_position_buffer: double-buffered ball table; the host fills the shadow bank and the
// active bank takes a copy of it only on a frame-end pulse, so a frame never shows a torn table.
module ball_position_buffer #(
   parameter int N_BALLS = 11,
   parameter int X_W = 10,
   parameter int Y_W = 9
) (
   input  logic                   iCLK,
   input  logic                   iRST_n,
   input  logic                   iWrEn,
   input  logic [3:0]             iWrAddr,
   input  logic [X_W-1:0]         iWrX,
   input  logic [Y_W-1:0]         iWrY,
   input  logic                   iClear,
   input  logic                   iPlayer,
   input  logic [1:0]             iScreenType,
   input  logic                   iCommit,
   input  logic                   iEndFrame,
   output logic [N_BALLS*X_W-1:0] oX,
   output logic [N_BALLS*Y_W-1:0] oY,
   output logic                   oPlayer,
   output logic [1:0]             oScreenType,
   output logic                   oCommitPending,
   output logic                   oCommitDone,
   output logic                   oWrErr,
   output logic [15:0]            oFrameCnt
);
   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
   localparam logic [3:0] LAST = 4'(N_BALLS - 1);
   logic [X_W-1:0] shX [N_BALLS];
   logic [Y_W-1:0] shY [N_BALLS];
   logic [X_W-1:0] acX [N_BALLS];
   logic [Y_W-1:0] acY [N_BALLS];
   logic           shPlayer;
   logic [1:0]     shScreenType;
   logic           inRange;
   state_t         state, nextState;
   assign inRange = iWrAddr <= LAST;
   assign oCommitPending = state == ARMED;
   assign oCommitDone = state == DONE;
   // IDLE and DONE both arm on iCommit; only ARMED looks at iEndFrame
   always_comb begin
      nextState = (state == ARMED) ? (iEndFrame ? DONE : ARMED) : (iCommit ? ARMED : IDLE);
   end
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state <= IDLE;
         oWrErr <= 1'b0;
         oFrameCnt <= '0;
      end else begin
         state <= nextState;
         oWrErr <= iWrEn && !inRange;
         oFrameCnt <= oFrameCnt + 16'(iEndFrame);
      end
   end
   // a write on the same edge as a clear wins for its own slot
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int k = 0; k < N_BALLS; k++) begin
            shX[k] <= '0;
            shY[k] <= '0;
         end
         shPlayer <= 1'b0;
         shScreenType <= '0;
      end else begin
         for (int k = 0; k < N_BALLS; k++) begin
            if (iClear) begin
               shX[k] <= '0;
               shY[k] <= '0;
            end
         end
         if (iWrEn && inRange) begin
            shX[iWrAddr] <= iWrX;
            shY[iWrAddr] <= iWrY;
         end
         shPlayer <= iPlayer;
         shScreenType <= iScreenType;
      end
   end
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int k = 0; k < N_BALLS; k++) begin
            acX[k] <= '0;
            acY[k] <= '0;
         end
         oPlayer <= 1'b0;
         oScreenType <= '0;
      end else if (state == ARMED && iEndFrame) begin
         for (int k = 0; k < N_BALLS; k++) begin
            acX[k] <= shX[k];
            acY[k] <= shY[k];
         end
         oPlayer <= shPlayer;
         oScreenType <= shScreenType;
      end
   end
   for (genvar g = 0; g < N_BALLS; g++) begin : g_pack
      assign oX[g*X_W +: X_W] = acX[g];
      assign oY[g*Y_W +: Y_W] = acY[g];
   end
endmodule

// File: tb/tb_ball_position_buffer.sv
// tb_ball_position_buffer: random and directed stimulus against a queue-based reference of the
// shadow/active tables; a negedge monitor pops expected commits and write errors as they appear.
module tb_ball_position_buffer;
   localparam int NB = 11;
   localparam int W = NB * 10 + NB * 9 + 3;
   logic            iCLK = 1'b0, iRST_n = 1'b0;
   logic            iWrEn = 1'b0, iClear = 1'b0, iPlayer = 1'b0, iCommit = 1'b0, iEndFrame = 1'b0;
   logic [3:0]      iWrAddr = '0;
   logic [9:0]      iWrX = '0;
   logic [8:0]      iWrY = '0;
   logic [1:0]      iScreenType = '0;
   logic [NB*10-1:0] oX;
   logic [NB*9-1:0] oY;
   logic            oPlayer, oCommitPending, oCommitDone, oWrErr;
   logic [1:0]      oScreenType;
   logic [15:0]     oFrameCnt;
   logic [9:0]      mShX [NB];
   logic [8:0]      mShY [NB];
   logic            mShPl, mPend;
   logic [1:0]      mShSt;
   logic [W-1:0]    mAct, cQ [$];
   logic [15:0]     mFc;
   int              cCycQ [$], eQ [$];
   int              cyc = 0, checks = 0, errors = 0;
   bit              chkEn = 0;

   ball_position_buffer dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrX(iWrX), .iWrY(iWrY),
      .iClear(iClear), .iPlayer(iPlayer), .iScreenType(iScreenType), .iCommit(iCommit),
      .iEndFrame(iEndFrame), .oX(oX), .oY(oY), .oPlayer(oPlayer), .oScreenType(oScreenType),
      .oCommitPending(oCommitPending), .oCommitDone(oCommitDone), .oWrErr(oWrErr),
      .oFrameCnt(oFrameCnt)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   function automatic logic [W-1:0] shadowPack();
      logic [W-1:0] v = '0;
      for (int k = 0; k < NB; k++) begin
         v[102 + k*10 +: 10] = mShX[k];
         v[3 + k*9 +: 9] = mShY[k];
      end
      v[2] = mShPl;
      v[1:0] = mShSt;
      return v;
   endfunction

   function automatic void modelReset();
      for (int k = 0; k < NB; k++) begin
         mShX[k] = '0;
         mShY[k] = '0;
      end
      mShPl = 0; mShSt = '0; mPend = 0; mAct = '0; mFc = '0;
   endfunction

   // drive one cycle and advance the reference by the same edge
   task automatic step(input logic we, input logic [3:0] a, input logic [9:0] x, input logic [8:0] y,
                       input logic clr, input logic cm, input logic ef);
      iWrEn = we; iWrAddr = a; iWrX = x; iWrY = y; iClear = clr; iCommit = cm; iEndFrame = ef;
      @(posedge iCLK);
      cyc++;
      if (mPend && ef) begin
         mAct = shadowPack();
         cQ.push_back(mAct);
         cCycQ.push_back(cyc);
      end
      mPend = mPend ? !ef : cm;
      if (clr)
         for (int k = 0; k < NB; k++) begin
            mShX[k] = '0;
            mShY[k] = '0;
         end
      if (we && a < 4'd11) begin
         mShX[a] = x;
         mShY[a] = y;
      end
      if (we && a >= 4'd11) eQ.push_back(cyc);
      mShPl = iPlayer;
      mShSt = iScreenType;
      mFc = mFc + 16'(ef);
      @(negedge iCLK);
      iWrEn = 0; iClear = 0; iCommit = 0; iEndFrame = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge iCLK) begin
      if (chkEn) begin
         check("pending", W'(oCommitPending), W'(mPend));
         check("frameCnt", W'(oFrameCnt), W'(mFc));
         check("activeHold", {oX, oY, oPlayer, oScreenType}, mAct);
         if (oCommitDone) begin
            if (cQ.size() == 0) check("commitDoneSpurious", 1, 0);
            else begin
               check("commitBank", {oX, oY, oPlayer, oScreenType}, cQ.pop_front());
               check("commitCycle", W'(cyc), W'(cCycQ.pop_front()));
            end
         end
         if (oWrErr) begin
            if (eQ.size() == 0) check("wrErrSpurious", 1, 0);
            else check("wrErrCycle", W'(cyc), W'(eQ.pop_front()));
         end
      end
   end

   initial begin
      modelReset();
      repeat (3) @(negedge iCLK);
      check("rstActive", {oX, oY, oPlayer, oScreenType}, '0);
      check("rstFlags", W'({oCommitPending, oCommitDone, oWrErr}), '0);
      check("rstFrameCnt", W'(oFrameCnt), '0);
      iRST_n = 1;
      chkEn = 1;
      // write without commit: frame end copies nothing
      step(1, 0, 100, 200, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      check("noCommitX0", W'(oX[9:0]), '0);
      check("noCommitCnt", W'(oFrameCnt), W'(1));
      // commit with frame end ten cycles later
      iPlayer = 1;
      step(1, 3, 446, 263, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      idle(9);
      step(0, 0, 0, 0, 0, 0, 1);
      check("slot3X", W'(oX[30 +: 10]), W'(446));
      check("slot3Y", W'(oY[27 +: 9]), W'(263));
      check("player", W'(oPlayer), W'(1));
      idle(1);
      // a write on the frame-end cycle misses that commit
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 5, 300, 150, 0, 0, 1);
      idle(2);
      check("slot5Excluded", W'(oX[50 +: 10]), '0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      check("slot5Committed", W'(oX[50 +: 10]), W'(300));
      // out-of-range writes
      step(1, 11, 1, 1, 0, 0, 0);
      step(1, 15, 2, 2, 0, 0, 0);
      idle(2);
      // fill every slot, then clear plus write in one cycle
      for (int k = 0; k < NB; k++) step(1, 4'(k), 10'(k + 1), 9'(k + 7), 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      step(1, 2, 50, 60, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      check("clearOnlySlot2X", W'(oX), W'(110'(50) << 20));
      check("clearOnlySlot2Y", W'(oY), W'(99'(60) << 18));
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         iPlayer = 1'($urandom);
         iScreenType = 2'($urandom);
         step($urandom_range(0, 99) < 40, 4'($urandom), 10'($urandom), 9'($urandom),
              $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      end
      idle(3);
      // asynchronous reset while armed, then frame counter wrap
      step(0, 0, 0, 0, 0, 1, 0);
      idle(2);
      check("armedBeforeReset", W'(oCommitPending), W'(1));
      #2 iRST_n = 0;
      #1;
      chkEn = 0;
      check("asyncRstActive", {oX, oY, oPlayer, oScreenType}, '0);
      check("asyncRstFlags", W'({oCommitPending, oCommitDone, oWrErr}), '0);
      check("asyncRstCnt", W'(oFrameCnt), '0);
      modelReset();
      cQ.delete(); cCycQ.delete(); eQ.delete();
      iPlayer = 0; iScreenType = 0;
      @(negedge iCLK);
      iRST_n = 1;
      chkEn = 1;
      for (int i = 0; i < 65536; i++) step(0, 0, 0, 0, 0, 0, 1);
      check("frameCntWrap", W'(oFrameCnt), '0);
      check("commitQueueDrained", W'(cQ.size()), '0);
      check("wrErrQueueDrained", W'(eQ.size()), '0);
      chkEn = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ball_position_buffer.md
Name: ball_position_buffer

Overview:
- Double-buffered ball-position register bank sitting directly upstream of mtl_display_controller.
- The host side (SPI/Nios bridge) writes ball coordinates, the active player and the screen type into a shadow bank at any time, then requests a commit.
- The commit copies the shadow bank to the active bank only on the controller's oEndFrame pulse, so a frame never shows a half-updated table.
- The active bank drives the controller's iX1..iX11, iY1..iY11, player and screenType inputs.

Parameters:
- N_BALLS, 11, number of ball slots (slot k maps to controller ball k+1).
- X_W, 10, X coordinate width.
- Y_W, 9, Y coordinate width.

Ports:
- iCLK  in  1  pixel/LCD clock, same clock as the display controller.
- iRST_n  in  1  reset; asynchronous, active-low.
- iWrEn  in  1  write strobe for one shadow slot, sampled on the rising edge.
- iWrAddr  in  4  shadow slot index, 0..N_BALLS-1.
- iWrX  in  X_W  X coordinate to write.
- iWrY  in  Y_W  Y coordinate to write.
- iClear  in  1  pulse; zeroes all shadow coordinates (0,0 = ball not drawn).
- iPlayer  in  1  shadow player value, sampled every cycle.
- iScreenType  in  2  shadow screen type, sampled every cycle.
- iCommit  in  1  pulse; requests shadow-to-active copy at the next frame end.
- iEndFrame  in  1  oEndFrame pulse from mtl_display_controller.
- oX  out  N_BALLS*X_W  active X coordinates, slot k at bits [k*X_W +: X_W].
- oY  out  N_BALLS*Y_W  active Y coordinates, slot k at bits [k*Y_W +: Y_W].
- oPlayer  out  1  active player.
- oScreenType  out  2  active screen type.
- oCommitPending  out  1  high while a commit is armed and not yet applied.
- oCommitDone  out  1  one-cycle pulse after the active bank updates.
- oWrErr  out  1  one-cycle pulse on a write to an out-of-range address.
- oFrameCnt  out  16  count of iEndFrame pulses, wraps at 65535 -> 0.

Behaviour:
- Reset (asynchronous, iRST_n=0):
  - Shadow and active banks are all zero; oPlayer=0, oScreenType=0.
  - oCommitPending=0, oCommitDone=0, oWrErr=0, oFrameCnt=0, FSM in IDLE.
  - Reset asserted mid-commit abandons the commit; no partial copy.
- Shadow write:
  - On iWrEn=1 with iWrAddr<N_BALLS, shadow[iWrAddr] <= {iWrX,iWrY} at that edge.
  - On iWrEn=1 with iWrAddr>=N_BALLS, no write; oWrErr=1 on the next cycle for exactly one cycle.
- Clear:
  - iClear=1 zeroes every shadow slot at that edge.
  - If iWrEn=1 on the same cycle, the written slot takes the new value and all other slots clear.
- Shadow player/screenType register iPlayer/iScreenType every cycle.
- FSM states:
  - IDLE: iCommit=1 -> ARMED. iEndFrame is not looked at in this state, so iCommit and iEndFrame on the same cycle still -> ARMED, and the copy waits for the next frame end.
  - ARMED: oCommitPending=1. iCommit is ignored (the request is already armed). On iEndFrame=1, at that edge the active bank takes the shadow bank, player and screenType as they were before the edge, and the FSM -> DONE. A write or clear in that same cycle lands in shadow only and is excluded from this commit.
  - DONE: oCommitPending=0, oCommitDone=1 for this single cycle. Next state: ARMED if iCommit=1, else IDLE.
- Latency:
  - Active outputs change exactly one edge after the iEndFrame cycle.
  - oCommitDone is high during the cycle after that edge.
  - Active outputs are held constant at all other times.
- Active outputs are direct register outputs with no combinational path from any input.
- oFrameCnt increments on every iEndFrame=1, independent of FSM state.

Test Plan:
- Reset, then write slot 0 = (100,200) with no commit, then pulse iEndFrame -> oX/oY remain 0, oFrameCnt=1, oCommitPending=0.
- Write slot 3 = (446,263), set iPlayer=1, pulse iCommit, iEndFrame 10 cycles later -> oCommitPending high for 10 cycles; oX[3]=446, oY[3]=263, oPlayer=1 one edge after iEndFrame; oCommitDone pulses once.
- While ARMED, write slot 5 = (300,150) in the same cycle as iEndFrame -> slot 5 stays 0 in the active bank; a second commit plus iEndFrame -> oX[5]=300.
- Write iWrAddr=11 and iWrAddr=15 -> oWrErr pulses one cycle each; no slot changes.
- Commit slots 0..10 nonzero, then iClear together with iWrEn slot 2 = (50,60), commit, iEndFrame -> only slot 2 nonzero in the active bank.
- Pulse iCommit then assert iRST_n=0 mid-ARMED -> all outputs 0 at once; a later iEndFrame causes no copy; 65536 iEndFrame pulses -> oFrameCnt wraps to 0.
